elev_sched: RTL and testbench

ELEV_SCHED -- requirements
Module: elev_sched

---
 rtl/elev_pkg.sv | 23 ++
 rtl/elev_sched_if.sv | 24 ++
 rtl/elev_call_scan.sv | 40 ++++
 rtl/elev_sched.sv | 160 ++++++++++++++++
 tb/tb_elev_sched.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/elev_pkg.sv
// Shared types for the elevator scheduler: FSM state encoding and direction codes.
package elev_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2,
        DOOR = 2'd3
    } state_e;

    localparam logic [1:0] DIR_DOWN = 2'd0;
    localparam logic [1:0] DIR_IDLE = 2'd1;
    localparam logic [1:0] DIR_UP   = 2'd2;

    function automatic logic [1:0] dir_of(input state_e s);
        case (s)
            UP:      return DIR_UP;
            DOWN:    return DIR_DOWN;
            default: return DIR_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/elev_sched_if.sv
// Panel/car-control bundle between the elevator scheduler and its surroundings.
interface elev_sched_if #(
    parameter int FLOORS  = 8,
    parameter int FLOOR_W = 3
);
    logic               tick;
    logic [FLOORS-1:0]  call_req;
    logic               hold;
    logic [FLOORS-1:0]  call_pend;
    logic [FLOOR_W-1:0] floor;
    logic [1:0]         dir;
    logic               door_open;
    logic               arrive;

    modport master (
        output tick, call_req, hold,
        input  call_pend, floor, dir, door_open, arrive
    );

    modport slave (
        input  tick, call_req, hold,
        output call_pend, floor, dir, door_open, arrive
    );
endinterface

// File: rtl/elev_call_scan.sv
// Combinational scan of pending calls relative to a floor: calls above/below and
// whether the nearest call lies upward (ties resolve upward).
module elev_call_scan #(
    parameter int FLOORS  = 8,
    parameter int FLOOR_W = 3
) (
    input  logic [FLOORS-1:0]  calls_i,
    input  logic [FLOOR_W-1:0] floor_i,
    output logic               any_above_o,
    output logic               any_below_o,
    output logic               nearest_up_o
);

    logic [FLOOR_W-1:0] up_idx;
    logic [FLOOR_W-1:0] dn_idx;

    // Downward loop leaves the lowest call above; upward loop the highest below.
    always_comb begin
        any_above_o = 1'b0;
        any_below_o = 1'b0;
        up_idx      = '0;
        dn_idx      = '0;
        for (int i = FLOORS - 1; i >= 0; i--) begin
            if (calls_i[i] && (FLOOR_W'(i) > floor_i)) begin
                any_above_o = 1'b1;
                up_idx      = FLOOR_W'(i);
            end
        end
        for (int i = 0; i < FLOORS; i++) begin
            if (calls_i[i] && (FLOOR_W'(i) < floor_i)) begin
                any_below_o = 1'b1;
                dn_idx      = FLOOR_W'(i);
            end
        end
    end

    assign nearest_up_o = any_above_o &&
                          (!any_below_o || ((up_idx - floor_i) <= (floor_i - dn_idx)));

endmodule

// File: rtl/elev_sched.sv
// Single-car elevator scheduler: latches floor calls, moves one floor per
// MOVE_TICKS strobes, opens the door for DOOR_TICKS strobes at served floors.
module elev_sched
    import elev_pkg::*;
#(
    parameter int FLOORS     = 8,
    parameter int FLOOR_W    = 3,
    parameter int MOVE_TICKS = 4,
    parameter int DOOR_TICKS = 8
) (
    input  logic       clk_fs,
    input  logic       rst_n,
    elev_sched_if.slave bus
);

    localparam int MV_W = (MOVE_TICKS > 1) ? $clog2(MOVE_TICKS) : 1;
    localparam int DR_W = (DOOR_TICKS > 1) ? $clog2(DOOR_TICKS) : 1;

    state_e             state_q, state_d;
    state_e             prev_q, prev_d;
    logic [FLOOR_W-1:0] floor_q, floor_d;
    logic [FLOORS-1:0]  pend_q, pend_d;
    logic [MV_W-1:0]    mv_q, mv_d;
    logic [DR_W-1:0]    dr_q, dr_d;
    logic [1:0]         dir_q;
    logic               door_open_q;
    logic               arrive_q;

    logic               moving;
    logic               mv_last;
    logic               dr_last;
    logic               stepping;
    logic               enter_door;
    logic [FLOOR_W-1:0] floor_nx;
    logic [FLOOR_W-1:0] scan_floor;
    logic [FLOORS-1:0]  scan_calls;
    logic               any_above;
    logic               any_below;
    logic               nearest_up;

    assign moving   = (state_q == UP) || (state_q == DOWN);
    assign mv_last  = (mv_q == MV_W'(MOVE_TICKS - 1));
    assign dr_last  = (dr_q == DR_W'(DOOR_TICKS - 1));
    assign stepping = moving && bus.tick && mv_last;
    assign floor_nx = (state_q == UP) ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);

    // On a step, decisions are made from the floor being entered. In IDLE the
    // raw requests are folded in so a call at the current floor opens the door
    // next cycle without ever showing as pending.
    assign scan_floor = stepping ? floor_nx : floor_q;
    assign scan_calls = (state_q == IDLE) ? (pend_q | bus.call_req) : pend_q;

    elev_call_scan #(
        .FLOORS  (FLOORS),
        .FLOOR_W (FLOOR_W)
    ) u_scan (
        .calls_i      (scan_calls),
        .floor_i      (scan_floor),
        .any_above_o  (any_above),
        .any_below_o  (any_below),
        .nearest_up_o (nearest_up)
    );

    always_comb begin
        state_d = state_q;
        floor_d = floor_q;
        mv_d    = mv_q;
        dr_d    = dr_q;
        case (state_q)
            IDLE: begin
                if (scan_calls[floor_q])        state_d = DOOR;
                else if (any_above && any_below) state_d = nearest_up ? UP : DOWN;
                else if (any_above)             state_d = UP;
                else if (any_below)             state_d = DOWN;
            end
            UP, DOWN: begin
                if (bus.tick) begin
                    if (mv_last) begin
                        mv_d    = '0;
                        floor_d = floor_nx;
                        if (pend_q[floor_nx])
                            state_d = DOOR;
                        else if ((state_q == UP) ? any_above : any_below)
                            state_d = state_q;
                        else if ((state_q == UP) ? any_below : any_above)
                            state_d = (state_q == UP) ? DOWN : UP;
                        else
                            state_d = IDLE;
                    end else begin
                        mv_d = mv_q + MV_W'(1);
                    end
                end
            end
            DOOR: begin
                if (bus.hold || bus.call_req[floor_q]) begin
                    dr_d = '0;
                end else if (bus.tick) begin
                    if (dr_last) begin
                        dr_d = '0;
                        case (prev_q)
                            UP:      state_d = any_above ? UP : (any_below ? DOWN : IDLE);
                            DOWN:    state_d = any_below ? DOWN : (any_above ? UP : IDLE);
                            default: state_d = IDLE;
                        endcase
                    end else begin
                        dr_d = dr_q + DR_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign enter_door = (state_d == DOOR) && (state_q != DOOR);

    // Direction of travel is remembered on door entry so the exit can resume it.
    always_comb begin
        prev_d = prev_q;
        if (enter_door) prev_d = state_q;
    end

    always_comb begin
        logic [FLOORS-1:0] set;
        set = bus.call_req;
        if (state_q == DOOR) set[floor_q] = 1'b0;
        pend_d = pend_q | set;
        if (enter_door) pend_d[floor_d] = 1'b0;
    end

    always_ff @(posedge clk_fs or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            prev_q      <= IDLE;
            floor_q     <= '0;
            pend_q      <= '0;
            mv_q        <= '0;
            dr_q        <= '0;
            dir_q       <= DIR_IDLE;
            door_open_q <= 1'b0;
            arrive_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            floor_q     <= floor_d;
            pend_q      <= pend_d;
            mv_q        <= mv_d;
            dr_q        <= dr_d;
            dir_q       <= dir_of(state_d);
            door_open_q <= (state_d == DOOR);
            arrive_q    <= enter_door;
        end
    end

    assign bus.call_pend = pend_q;
    assign bus.floor     = floor_q;
    assign bus.dir       = dir_q;
    assign bus.door_open = door_open_q;
    assign bus.arrive    = arrive_q;

endmodule

// File: tb/tb_elev_sched.sv
// Scoreboarded bench for elev_sched: expected arrivals (floor, door-open ticks)
// are queued by the stimulus and checked by an independent arrive monitor.
module tb_elev_sched;
    import elev_pkg::*;

    typedef struct {
        int fl;
        int dt;
    } arr_t;

    logic clk_fs;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    arr_t exp_q[$];

    elev_sched_if #(.FLOORS(8), .FLOOR_W(3)) bus ();

    elev_sched #(
        .FLOORS     (8),
        .FLOOR_W    (3),
        .MOVE_TICKS (4),
        .DOOR_TICKS (8)
    ) dut (
        .clk_fs (clk_fs),
        .rst_n  (rst_n),
        .bus    (bus.slave)
    );

    initial clk_fs = 1'b0;
    always #5 clk_fs = ~clk_fs;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h @%0t", nm, act, exp, $time);
        end
    endtask

    task automatic tk(input int n);
        repeat (n) begin
            @(posedge clk_fs); #2 bus.tick = 1'b1;
            @(posedge clk_fs); #2 bus.tick = 1'b0;
        end
    endtask

    task automatic call(input logic [7:0] m);
        @(posedge clk_fs); #2 bus.call_req = m;
        @(posedge clk_fs); #2 bus.call_req = '0;
    endtask

    task automatic expect_arr(input int fl, input int dt);
        arr_t e;
        e.fl = fl;
        e.dt = dt;
        exp_q.push_back(e);
    endtask

    // Monitor: each arrive pulse pops one expectation, checks the floor, then
    // counts tick strobes consumed while the door stays open.
    initial begin
        arr_t e;
        int   cnt;
        int   n;
        forever begin
            @(negedge clk_fs);
            if (bus.arrive === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexp_arrive", 32'(bus.floor), 32'hFFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("arr_floor", 32'(bus.floor), 32'(e.fl));
                    cnt = 0;
                    n   = 0;
                    while (bus.door_open === 1'b1 && n < 3000) begin
                        if (bus.tick === 1'b1) cnt++;
                        @(negedge clk_fs);
                        n++;
                    end
                    chk("door_ticks", 32'(cnt), 32'(e.dt));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        bus.tick     = 1'b0;
        bus.call_req = '0;
        bus.hold     = 1'b0;
        repeat (3) @(posedge clk_fs);
        #2;
        chk("rst_floor", 32'(bus.floor), 0);
        chk("rst_pend",  32'(bus.call_pend), 0);
        chk("rst_dir",   32'(bus.dir), 32'(DIR_IDLE));
        chk("rst_door",  32'(bus.door_open), 0);
        chk("rst_arr",   32'(bus.arrive), 0);
        rst_n = 1'b1;

        // Single call to floor 5: 5 floors * 4 ticks, 8-tick door, then idle.
        expect_arr(5, 8);
        call(8'h20);
        chk("t1_dir_up", 32'(bus.dir), 32'(DIR_UP));
        chk("t1_pend",   32'(bus.call_pend), 32'h20);
        tk(19);
        chk("t1_floor4", 32'(bus.floor), 4);
        chk("t1_door0",  32'(bus.door_open), 0);
        tk(1);
        chk("t1_floor5", 32'(bus.floor), 5);
        chk("t1_door1",  32'(bus.door_open), 1);
        chk("t1_pendclr", 32'(bus.call_pend), 0);
        tk(7);
        chk("t1_door_7", 32'(bus.door_open), 1);
        tk(1);
        chk("t1_closed", 32'(bus.door_open), 0);
        chk("t1_idle",   32'(bus.dir), 32'(DIR_IDLE));

        // Park at 3, then calls 1 and 6: nearer one (1) first.
        expect_arr(3, 8);
        call(8'h08);
        chk("t2_dir_dn0", 32'(bus.dir), 32'(DIR_DOWN));
        tk(16);
        chk("t2_at3", 32'(bus.floor), 3);
        expect_arr(1, 8);
        expect_arr(6, 8);
        call(8'h42);
        chk("t2_dir_dn", 32'(bus.dir), 32'(DIR_DOWN));
        chk("t2_pend",   32'(bus.call_pend), 32'h42);
        tk(8);
        chk("t2_at1",    32'(bus.floor), 1);
        chk("t2_door1",  32'(bus.door_open), 1);
        chk("t2_pend6",  32'(bus.call_pend), 32'h40);
        tk(8);
        chk("t2_dir_up", 32'(bus.dir), 32'(DIR_UP));
        tk(20);
        chk("t2_at6",    32'(bus.floor), 6);
        chk("t2_door6",  32'(bus.door_open), 1);
        tk(8);

        // From 0 toward 7, floor 4 called while between 3 and 4.
        expect_arr(0, 8);
        call(8'h01);
        tk(32);
        chk("t3_at0", 32'(bus.floor), 0);
        expect_arr(4, 8);
        expect_arr(7, 8);
        call(8'h80);
        tk(12);
        chk("t3_at3", 32'(bus.floor), 3);
        call(8'h10);
        chk("t3_pend", 32'(bus.call_pend), 32'h90);
        tk(4);
        chk("t3_at4",   32'(bus.floor), 4);
        chk("t3_door4", 32'(bus.door_open), 1);
        tk(8);
        chk("t3_resume", 32'(bus.dir), 32'(DIR_UP));
        tk(12);
        chk("t3_at7", 32'(bus.floor), 7);
        tk(8);

        // Call at the current top floor while idle: door next cycle, never pending.
        expect_arr(7, 8);
        call(8'h80);
        chk("t5_door",  32'(bus.door_open), 1);
        chk("t5_pend",  32'(bus.call_pend), 0);
        call(8'h80);
        chk("t5_pend2", 32'(bus.call_pend), 0);
        tk(8);
        chk("t5_closed", 32'(bus.door_open), 0);
        chk("t5_floor7", 32'(bus.floor), 7);
        chk("t5_dir",    32'(bus.dir), 32'(DIR_IDLE));

        // Door held at floor 2 for 20 ticks, then 8 more ticks to close.
        expect_arr(2, 28);
        call(8'h04);
        tk(20);
        chk("t4_at2", 32'(bus.floor), 2);
        bus.hold = 1'b1;
        tk(20);
        chk("t4_held", 32'(bus.door_open), 1);
        bus.hold = 1'b0;
        tk(7);
        chk("t4_open7", 32'(bus.door_open), 1);
        tk(1);
        chk("t4_closed", 32'(bus.door_open), 0);

        // Reset mid-move at floor 4: immediate abort, no arrive afterwards.
        call(8'h80);
        tk(8);
        chk("t6_at4", 32'(bus.floor), 4);
        tk(2);
        rst_n = 1'b0;
        #1;
        chk("t6_floor", 32'(bus.floor), 0);
        chk("t6_pend",  32'(bus.call_pend), 0);
        chk("t6_dir",   32'(bus.dir), 32'(DIR_IDLE));
        chk("t6_door",  32'(bus.door_open), 0);
        repeat (3) @(posedge clk_fs);
        #2 rst_n = 1'b1;
        tk(8);
        chk("t6_stay0", 32'(bus.floor), 0);
        chk("t6_idle",  32'(bus.dir), 32'(DIR_IDLE));
        repeat (5) @(posedge clk_fs);
        #2;
        chk("sb_drained", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
